// File: rtl/dq_bank_ctrl.sv
// Sequencing controller and round-robin two-port arbiter for a bank of DQ latch words.
// Each write becomes a setup / one-hot enable pulse / hold sequence; reads register the addressed Q word.
module dq_bank_ctrl #(
  parameter int WIDTH = 4,
  parameter int AW    = 2,
  parameter int PULSE = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      a_req,
  input  logic                      a_we,
  input  logic [AW-1:0]             a_addr,
  input  logic [WIDTH-1:0]          a_wdata,
  output logic                      a_gnt,
  output logic                      a_done,
  input  logic                      b_req,
  input  logic                      b_we,
  input  logic [AW-1:0]             b_addr,
  input  logic [WIDTH-1:0]          b_wdata,
  output logic                      b_gnt,
  output logic                      b_done,
  output logic [WIDTH-1:0]          rdata,
  output logic                      busy,
  output logic [WIDTH-1:0]          cell_d,
  output logic [(2**AW)-1:0]        cell_en,
  input  logic [WIDTH*(2**AW)-1:0]  cell_q
);

  localparam int NW = 2**AW;
  localparam int CW = (PULSE > 1) ? $clog2(PULSE) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_READ
  } state_t;

  state_t          state;
  logic            ptr_b;
  logic            cur_b;
  logic [AW-1:0]   addr_r;
  logic [CW-1:0]   cnt;
  logic            pick_b;

  function automatic logic [NW-1:0] onehot(input logic [AW-1:0] a);
    logic [NW-1:0] v;
    v    = '0;
    v[a] = 1'b1;
    return v;
  endfunction

  // B wins when it is the sole requester or holds the priority pointer.
  always_comb begin
    pick_b = 1'b0;
    if (b_req && (!a_req || ptr_b))
      pick_b = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      ptr_b   <= 1'b0;
      cur_b   <= 1'b0;
      addr_r  <= '0;
      cnt     <= '0;
      a_gnt   <= 1'b0;
      b_gnt   <= 1'b0;
      a_done  <= 1'b0;
      b_done  <= 1'b0;
      busy    <= 1'b0;
      cell_d  <= '0;
      cell_en <= '0;
      rdata   <= '0;
    end else begin
      a_gnt  <= 1'b0;
      b_gnt  <= 1'b0;
      a_done <= 1'b0;
      b_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (a_req || b_req) begin
            cur_b  <= pick_b;
            ptr_b  <= !pick_b;
            a_gnt  <= !pick_b;
            b_gnt  <= pick_b;
            addr_r <= pick_b ? b_addr : a_addr;
            busy   <= 1'b1;
            // cell_d moves only here, while every enable is low.
            if (pick_b ? b_we : a_we) begin
              cell_d <= pick_b ? b_wdata : a_wdata;
              state  <= S_SETUP;
            end else begin
              state  <= S_READ;
            end
          end
        end
        S_SETUP: begin
          cell_en <= onehot(addr_r);
          cnt     <= CW'(PULSE - 1);
          state   <= S_PULSE;
        end
        S_PULSE: begin
          if (cnt == '0) begin
            cell_en <= '0;
            a_done  <= !cur_b;
            b_done  <= cur_b;
            state   <= S_HOLD;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_HOLD: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        S_READ: begin
          rdata  <= cell_q[addr_r*WIDTH +: WIDTH];
          a_done <= !cur_b;
          b_done <= cur_b;
          busy   <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          cell_en <= '0;
          busy    <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule
